cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory port (pmem_*) between the instruction cache and the data cache of the pipelined rv32i CPU.
- The port carries 256-bit lines and uses a read/write/resp handshake.
- Each transaction is granted to one cache. The block latches the address and write data, then holds them until pmem_resp.
- Fixed priority with alternation when both caches request: no requester starves. Sits between the cache pair and magic_memory/physical memory.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
i_pmem_read  in  1  icache line-fill request
i_pmem_address  in  ADDR_WIDTH  icache line address
i_pmem_rdata  out  LINE_WIDTH  line data to icache
i_pmem_resp  out  1  icache transaction done (one-cycle pulse)
d_pmem_read  in  1  dcache line-fill request
d_pmem_write  in  1  dcache writeback request
d_pmem_address  in  ADDR_WIDTH  dcache line address
d_pmem_wdata  in  LINE_WIDTH  dcache writeback data
d_pmem_rdata  out  LINE_WIDTH  line data to dcache
d_pmem_resp  out  1  dcache transaction done (one-cycle pulse)
pmem_read  out  1  memory read strobe (registered)
pmem_write  out  1  memory write strobe (registered)
pmem_address  out  ADDR_WIDTH  latched address (registered)
pmem_wdata  out  LINE_WIDTH  latched write data (registered)
pmem_rdata  in  LINE_WIDTH  memory read data
pmem_resp  in  1  memory transaction done
busy  out  1  high whenever state != IDLE

Behaviour:
- States:
  - IDLE: no transaction. Outputs after reset: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, both resp=0, busy=0.
  - SERVE_I: icache granted.
  - SERVE_D: dcache granted.
  - Internal flag last_d records the last granted requester. It resets to 0.
- Arbitration, evaluated in IDLE only:
  - d_req = d_pmem_read | d_pmem_write; i_req = i_pmem_read.
  - Only d_req: go to SERVE_D. Only i_req: go to SERVE_I.
  - Both: go to SERVE_I if last_d=1, else SERVE_D. From reset, dcache wins the first tie.
- Grant cycle, on the IDLE→SERVE_x edge:
  - pmem_address and pmem_wdata latch the granted requester's inputs. wdata is latched as 0 for icache.
  - SERVE_I sets pmem_read=1.
  - SERVE_D sets pmem_write=d_pmem_write and pmem_read=~d_pmem_write. d_read and d_write both high is treated as a write.
  - last_d is updated.
  - Latency: request sampled in cycle N; strobe visible in cycle N+1.
- In SERVE_x:
  - Address, data and strobes are held stable regardless of requester input changes. Requesters must hold their request until their resp.
  - x_pmem_resp = pmem_resp, combinational, same cycle. The other requester's resp is 0.
- Read data:
  - i_pmem_rdata and d_pmem_rdata both equal pmem_rdata at all times (broadcast).
  - Only the resp gating selects the consumer.
- Completion:
  - On a cycle with pmem_resp=1 in SERVE_x, the next state is IDLE and strobes clear at that edge.
  - pmem_address and pmem_wdata retain their last values.
- Turnaround:
  - One mandatory IDLE cycle follows every completion, so a requester that deasserts after its resp is never re-served.
  - Back-to-back grants are therefore spaced by at least one IDLE cycle.
- Spurious input:
  - pmem_resp while in IDLE is ignored.
  - A requester dropping its request mid-transaction does not abort the transaction; the arbiter waits for pmem_resp.
- Reset:
  - rst_n=0 on any edge, including mid-transaction, forces IDLE, clears all strobes and registers, and sets last_d=0.
  - The outstanding memory transaction is abandoned and no resp is forwarded.

Test Plan:
- Reset, then icache read of 0x0000_0060; memory resp after 3 cycles with rdata=0xDEADBEEF repeated:
  - pmem_read rises 1 cycle after request, with pmem_address=0x60.
  - i_pmem_resp pulses in the same cycle as pmem_resp; i_pmem_rdata matches.
  - d_pmem_resp stays 0.
- Dcache write of 0x0000_0100 with wdata=0x97-pattern:
  - pmem_write=1, pmem_read=0, address and wdata latched.
  - Changing d_pmem_wdata mid-transaction does not alter pmem_wdata.
- Both request simultaneously after reset:
  - Dcache is served first. After its resp and one IDLE cycle, icache is served.
  - A repeated tie then grants icache first (alternation).
- d_read and d_write both asserted for 0x200: treated as a write (pmem_write=1, pmem_read=0).
- rst_n low two cycles into an icache read: next cycle shows pmem_read=0 and busy=0; a late pmem_resp produces no i_pmem_resp.
- pmem_resp pulsed while IDLE: no requester resp, state stays IDLE, busy=0.

Source files
------------

// File: rtl/cache_arbiter.sv
// Arbitrates the single pmem line port between the icache and the dcache.
// Grants one transaction at a time, holds address/data until pmem_resp, alternates on ties.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
  } pmem_req_t;

  state_t    state;
  state_t    state_next;
  pmem_req_t req;
  pmem_req_t req_next;
  logic      last_d;
  logic      last_d_next;
  logic      busy_next;
  logic      i_req;
  logic      d_req;
  logic      d_wins;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  // On a tie the dcache wins unless it was the last one granted.
  assign d_wins = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      req    <= '0;
      last_d <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      req    <= req_next;
      last_d <= last_d_next;
      busy   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state;
    req_next    = req;
    last_d_next = last_d;
    case (state)
      IDLE: begin
        if (d_wins) begin
          state_next       = SERVE_D;
          req_next.address = d_pmem_address;
          req_next.wdata   = d_pmem_wdata;
          req_next.write   = d_pmem_write;
          req_next.read    = ~d_pmem_write;
          last_d_next      = 1'b1;
        end else if (i_req) begin
          state_next       = SERVE_I;
          req_next.address = i_pmem_address;
          req_next.wdata   = '0;
          req_next.write   = 1'b0;
          req_next.read    = 1'b1;
          last_d_next      = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        // Completion always returns through IDLE, giving the requester a cycle to drop.
        if (pmem_resp) begin
          state_next     = IDLE;
          req_next.read  = 1'b0;
          req_next.write = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        req_next.read  = 1'b0;
        req_next.write = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  assign pmem_read    = req.read;
  assign pmem_write   = req.write;
  assign pmem_address = req.address;
  assign pmem_wdata   = req.wdata;

  // Read data is broadcast; only the resp gating selects the consumer.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever a requester resp fires.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;

  typedef struct packed {
    logic          is_d;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every requester resp must match the oldest expected entry.
  always @(negedge clk) begin
    if (i_pmem_resp || d_pmem_resp) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp act=i%0b/d%0b exp=none", i_pmem_resp, d_pmem_resp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_owner", 256'({i_pmem_resp, d_pmem_resp}), 256'({~e.is_d, e.is_d}));
        chk("resp_rdata", e.is_d ? d_pmem_rdata : i_pmem_rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One granted transaction: grant edge, hold cycles with requester inputs perturbed, resp, turnaround.
  task automatic serve(input bit is_d, input logic [AW-1:0] addr, input bit wr,
                       input logic [LW-1:0] wdata, input int delay,
                       input logic [LW-1:0] rdata, input bit drop, input string tag);
    tick();
    @(negedge clk);
    chk({tag, "_read"},  256'(pmem_read),  256'(wr ? 1'b0 : 1'b1));
    chk({tag, "_write"}, 256'(pmem_write), 256'(wr));
    chk({tag, "_addr"},  256'(pmem_address), 256'(addr));
    chk({tag, "_wdata"}, pmem_wdata, wdata);
    chk({tag, "_busy"},  256'(busy), 256'(1'b1));
    for (int k = 1; k < delay; k++) begin
      tick();
      if (is_d) begin
        d_pmem_address = d_pmem_address ^ 32'h0000_1000;
        d_pmem_wdata   = ~d_pmem_wdata;
      end else begin
        i_pmem_address = i_pmem_address ^ 32'h0000_1000;
      end
      @(negedge clk);
      chk({tag, "_hold_addr"},  256'(pmem_address), 256'(addr));
      chk({tag, "_hold_wdata"}, pmem_wdata, wdata);
    end
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    sb.push_back('{is_d: is_d, rdata: rdata});
    @(negedge clk);
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (drop) begin
      if (is_d) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_done_busy"},  256'(busy), 256'(1'b0));
    chk({tag, "_done_strb"},  256'({pmem_read, pmem_write}), 256'(2'b00));
    chk({tag, "_done_addr"},  256'(pmem_address), 256'(addr));
  endtask

  initial begin
    logic [LW-1:0] w;
    rst_n          = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_read",  256'(pmem_read),    '0);
    chk("rst_write", 256'(pmem_write),   '0);
    chk("rst_addr",  256'(pmem_address), '0);
    chk("rst_wdata", pmem_wdata,         '0);
    chk("rst_resp",  256'({i_pmem_resp, d_pmem_resp}), '0);
    chk("rst_busy",  256'(busy),         '0);
    tick();
    rst_n = 1'b1;

    // icache read, resp three cycles after the strobe appears
    tick();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0060;
    @(negedge clk);
    chk("i_req_cycle_read", 256'(pmem_read), '0);
    chk("i_req_cycle_busy", 256'(busy), '0);
    serve(1'b0, 32'h0000_0060, 1'b0, '0, 3, {8{32'hDEAD_BEEF}}, 1'b1, "i_rd");

    // dcache writeback, wdata changed while held
    tick();
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0100;
    d_pmem_wdata   = {32{8'h97}};
    serve(1'b1, 32'h0000_0100, 1'b1, {32{8'h97}}, 3, {8{32'h0BAD_F00D}}, 1'b1, "d_wr");

    // tie after reset: dcache first, then alternation gives icache the next tie
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    w              = {16{16'hA55A}};
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0080;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0140;
    d_pmem_wdata   = w;
    serve(1'b1, 32'h0000_0140, 1'b0, w, 2, {8{32'h1111_2222}}, 1'b0, "tie_d");
    d_pmem_address = 32'h0000_0180;
    serve(1'b0, 32'h0000_0080, 1'b0, '0, 2, {8{32'h3333_4444}}, 1'b1, "tie_i");
    serve(1'b1, 32'h0000_0180, 1'b0, d_pmem_wdata, 2, {8{32'h5555_6666}}, 1'b1, "tie_d2");

    // read and write together act as a write
    tick();
    w              = {8{32'hC0FF_EE00}};
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0200;
    d_pmem_wdata   = w;
    serve(1'b1, 32'h0000_0200, 1'b1, w, 2, {8{32'h7777_8888}}, 1'b1, "rw");

    // reset two cycles into an icache read abandons it
    tick();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0300;
    tick();
    @(negedge clk);
    chk("abort_grant_read", 256'(pmem_read), 256'(1'b1));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b1;
    pmem_rdata  = {8{32'h9999_AAAA}};
    @(negedge clk);
    chk("abort_read", 256'(pmem_read), '0);
    chk("abort_busy", 256'(busy), '0);
    chk("abort_addr", 256'(pmem_address), '0);
    chk("abort_resp", 256'({i_pmem_resp, d_pmem_resp}), '0);
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;

    // spurious pmem_resp while idle
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("idle_resp_fwd",  256'({i_pmem_resp, d_pmem_resp}), '0);
    chk("idle_resp_busy", 256'(busy), '0);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("idle_after_busy", 256'(busy), '0);
    chk("idle_after_strb", 256'({pmem_read, pmem_write}), '0);

    repeat (2) tick();
    chk("sb_drained", 256'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
